// File: rtl/btn_debounce4_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state
// encoding and the counter width helper.
package btn_debounce4_pkg;

    localparam logic [1:0] ST_LO_STABLE = 2'd0;
    localparam logic [1:0] ST_LO_TO_HI  = 2'd1;
    localparam logic [1:0] ST_HI_STABLE = 2'd2;
    localparam logic [1:0] ST_HI_TO_LO  = 2'd3;

    typedef enum logic [1:0] {
        LO_STABLE = ST_LO_STABLE,
        LO_TO_HI  = ST_LO_TO_HI,
        HI_STABLE = ST_HI_STABLE,
        HI_TO_LO  = ST_HI_TO_LO
    } db_state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2w(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/btn_debounce4_chan.sv
// One debounced button channel: 2-flop synchronizer, 4-state debounce FSM,
// stability counter and long-press hold counter, all outputs registered.
module db_chan
    import btn_debounce4_pkg::*;
#(
    parameter int DB_MS   = 10,
    parameter int LONG_MS = 1000
) (
    input  logic clk,
    input  logic R,
    input  logic ce1ms,
    input  logic btn_in,
    output logic btn_lvl,
    output logic btn_pe,
    output logic btn_ne,
    output logic btn_long
);

    localparam int DB_W   = clog2w(DB_MS + 1);
    localparam int HOLD_W = clog2w(LONG_MS + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);

    logic [1:0]        sync_q;
    logic              din;
    db_state_t         state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    assign din = sync_q[1];

    // NOTE: every register here uses <= so all flops sample pre-edge values;
    // blocking assignments would let later statements see updated state.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state    <= LO_STABLE;
            db_cnt   <= '0;
            hold_cnt <= '0;
            btn_lvl  <= 1'b0;
            btn_pe   <= 1'b0;
            btn_ne   <= 1'b0;
            btn_long <= 1'b0;
        end else begin
            btn_pe   <= 1'b0;
            btn_ne   <= 1'b0;
            btn_long <= 1'b0;

            // Hold time keeps running through a release bounce and saturates,
            // so a single press yields at most one long pulse.
            if ((state == HI_STABLE || state == HI_TO_LO) && ce1ms && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    btn_long <= 1'b1;
                end
            end

            case (state)
                LO_STABLE: begin
                    if (din) begin
                        state  <= LO_TO_HI;
                        db_cnt <= '0;
                    end
                end
                LO_TO_HI: begin
                    if (!din) begin
                        state <= LO_STABLE;
                    end else if (ce1ms) begin
                        db_cnt <= db_cnt + 1'b1;
                        if (db_cnt == DB_LAST) begin
                            state    <= HI_STABLE;
                            btn_lvl  <= 1'b1;
                            btn_pe   <= 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                end
                HI_STABLE: begin
                    if (!din) begin
                        state  <= HI_TO_LO;
                        db_cnt <= '0;
                    end
                end
                HI_TO_LO: begin
                    if (din) begin
                        state <= HI_STABLE;
                    end else if (ce1ms) begin
                        db_cnt <= db_cnt + 1'b1;
                        if (db_cnt == DB_LAST) begin
                            state   <= LO_STABLE;
                            btn_lvl <= 1'b0;
                            btn_ne  <= 1'b1;
                        end
                    end
                end
                default: state <= LO_STABLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce4.sv
// Multi-channel push-button debouncer with press/release/long-press pulses;
// one independent db_chan per button.
module btn_debounce4
    import btn_debounce4_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DB_MS   = 10,
    parameter int LONG_MS = 1000
) (
    input  logic            clk,
    input  logic            R,
    input  logic            ce1ms,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] btn_pe,
    output logic [N_CH-1:0] btn_ne,
    output logic [N_CH-1:0] btn_long
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        db_chan #(
            .DB_MS   (DB_MS),
            .LONG_MS (LONG_MS)
        ) u_chan (
            .clk      (clk),
            .R        (R),
            .ce1ms    (ce1ms),
            .btn_in   (btn_in[i]),
            .btn_lvl  (btn_lvl[i]),
            .btn_pe   (btn_pe[i]),
            .btn_ne   (btn_ne[i]),
            .btn_long (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce4.sv
// Directed bench for btn_debounce4 (DB_MS=10, LONG_MS=1000): clean press,
// bounce, long press, resets, simultaneous channels and gated ce1ms.
module tb_btn_debounce4;

    logic       clk = 1'b0;
    logic       R;
    logic       ce1ms;
    logic [3:0] btn_in;
    logic [3:0] btn_lvl;
    logic [3:0] btn_pe;
    logic [3:0] btn_ne;
    logic [3:0] btn_long;

    int checks   = 0;
    int failures = 0;
    int pe_cnt[4];
    int ne_cnt[4];
    int long_cnt[4];
    int both_cnt = 0;
    logic [3:0] seen;

    btn_debounce4 #(.N_CH(4), .DB_MS(10), .LONG_MS(1000)) dut (
        .clk      (clk),
        .R        (R),
        .ce1ms    (ce1ms),
        .btn_in   (btn_in),
        .btn_lvl  (btn_lvl),
        .btn_pe   (btn_pe),
        .btn_ne   (btn_ne),
        .btn_long (btn_long)
    );

    always #5 clk = ~clk;

    // Pulse accounting: reads pre-edge output values at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (btn_pe[i])   pe_cnt[i]++;
            if (btn_ne[i])   ne_cnt[i]++;
            if (btn_long[i]) long_cnt[i]++;
            if (btn_pe[i] && btn_ne[i]) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One millisecond = 4 clocks; returns on the falling edge just after the
    // ce1ms edge, so outputs of that tick are visible.
    task automatic do_ms(input int n);
        repeat (n) begin
            repeat (3) @(negedge clk);
            ce1ms = 1'b1;
            @(negedge clk);
            ce1ms = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pe_cnt[i] = 0; ne_cnt[i] = 0; long_cnt[i] = 0;
        end
        R = 1'b1; ce1ms = 1'b0; btn_in = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_lvl",  btn_lvl,  0);
        check("reset_pe",   btn_pe,   0);
        check("reset_ne",   btn_ne,   0);
        check("reset_long", btn_long, 0);
        R = 1'b0;
        do_ms(2);

        // Clean press on channel 0
        btn_in = 4'b0001;
        do_ms(9);
        check("press0_pre_lvl", btn_lvl, 4'b0000);
        do_ms(1);
        check("press0_lvl", btn_lvl, 4'b0001);
        check("press0_pe",  btn_pe,  4'b0001);
        @(negedge clk);
        check("press0_pe_width", btn_pe, 4'b0000);
        @(negedge clk);
        check("press0_pe_cnt", pe_cnt[0], 1);
        check("press0_others", pe_cnt[1] + pe_cnt[2] + pe_cnt[3] + ne_cnt[0] + long_cnt[0], 0);
        btn_in = 4'b0000;
        do_ms(9);
        check("rel0_pre_lvl", btn_lvl, 4'b0001);
        do_ms(1);
        check("rel0_lvl", btn_lvl, 4'b0000);
        check("rel0_ne",  btn_ne,  4'b0001);

        // Bounce on channel 1: 3 ms phases for 20 ms, then settle high
        for (int k = 0; k < 20; k++) begin
            btn_in[1] = ((k / 3) % 2) == 1;
            do_ms(1);
        end
        repeat (2) @(negedge clk);
        check("bounce1_no_pe", pe_cnt[1], 0);
        btn_in[1] = 1'b1;
        do_ms(9);
        check("bounce1_pre_lvl", btn_lvl, 4'b0000);
        do_ms(1);
        check("bounce1_pe", btn_pe, 4'b0010);
        repeat (2) @(negedge clk);
        check("bounce1_pe_cnt", pe_cnt[1], 1);
        btn_in[1] = 1'b0;
        do_ms(10);
        check("bounce1_rel_lvl", btn_lvl, 4'b0000);

        // Long press on channel 2 with a short release glitch mid-hold
        btn_in[2] = 1'b1;
        do_ms(10);
        check("long2_pe", btn_pe, 4'b0100);
        do_ms(500);
        btn_in[2] = 1'b0;
        do_ms(2);
        btn_in[2] = 1'b1;
        do_ms(497);
        check("long2_pre_long", btn_long, 4'b0000);
        check("long2_lvl_held", btn_lvl, 4'b0100);
        do_ms(1);
        check("long2_long", btn_long, 4'b0100);
        @(negedge clk);
        check("long2_long_width", btn_long, 4'b0000);
        do_ms(1490);
        repeat (2) @(negedge clk);
        check("long2_long_cnt", long_cnt[2], 1);
        btn_in[2] = 1'b0;
        do_ms(9);
        check("long2_rel_pre", btn_lvl, 4'b0100);
        do_ms(1);
        check("long2_ne", btn_ne, 4'b0100);
        check("long2_rel_lvl", btn_lvl, 4'b0000);

        // Reset mid-debounce, then requalification with input still high
        btn_in = 4'b0001;
        do_ms(5);
        R = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {btn_lvl, btn_pe, btn_ne, btn_long}, 16'h0000);
        R = 1'b0;
        do_ms(9);
        check("rst_mid_pre_lvl", btn_lvl, 4'b0000);
        do_ms(1);
        check("rst_mid_pe", btn_pe, 4'b0001);
        repeat (2) @(negedge clk);
        check("rst_mid_pe_cnt", pe_cnt[0], 2);

        // Reset mid-hold discards the release
        do_ms(20);
        btn_in = 4'b0000;
        R = 1'b1;
        @(negedge clk);
        check("rst_hold_lvl", btn_lvl, 4'b0000);
        R = 1'b0;
        do_ms(15);
        repeat (2) @(negedge clk);
        check("rst_hold_no_ne", ne_cnt[0], 1);

        // Simultaneous press and release on all channels
        btn_in = 4'b1111;
        do_ms(10);
        check("sim_pe",  btn_pe,  4'b1111);
        check("sim_lvl", btn_lvl, 4'b1111);
        btn_in = 4'b0000;
        do_ms(10);
        check("sim_ne",  btn_ne,  4'b1111);
        check("sim_lvl_low", btn_lvl, 4'b0000);

        // ce1ms held low for 50 ms: nothing may be accepted
        btn_in = 4'b0101;
        seen = 4'b0000;
        repeat (200) begin
            @(negedge clk);
            seen = seen | btn_lvl | btn_pe | btn_ne | btn_long;
        end
        check("gated_quiet", seen, 4'b0000);
        btn_in = 4'b0000;
        do_ms(3);
        check("gated_lvl_after", btn_lvl, 4'b0000);

        repeat (2) @(negedge clk);
        check("pe_ne_exclusive", both_cnt, 0);
        check("long_total", long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
